// File: rtl/dram_cmd_sequencer.sv
// dram_cmd_sequencer: closed-page DDR5 ACT/CAS/PRE sequencer for one request at a time.
// Ports: clk, rst (async, active high); req_valid/req_ready/req_op/req_addr request handshake;
// cmd_valid/cmd_type/cmd_channel/cmd_bg/cmd_bank/cmd_row/cmd_col command stream;
// busy (request in flight), done (tRP complete pulse), req_err (illegal op pulse).
module dram_cmd_sequencer #(
  parameter int tRCD   = 39,
  parameter int tCAS   = 40,
  parameter int tCWL   = 38,
  parameter int tBURST = 8,
  parameter int tWR    = 72,
  parameter int tRP    = 39
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [35:0] req_addr,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        busy,
  output logic        done,
  output logic        req_err
);
  typedef enum logic [3:0] {IDLE, ACT0, ACT1, WAIT_RCD, CAS0, CAS1, WAIT_PRE, PRE, WAIT_RP} state_t;
  // Counter loads: a wait state lasting n cycles is loaded with n-1 and exits at zero.
  // ACT1->CAS0 leaves tRCD-2 wait cycles, CAS1->PRE leaves latency-2, PRE->IDLE leaves tRP-1.
  localparam logic [7:0] LD_RCD = 8'(tRCD - 3);
  localparam logic [7:0] LD_RD  = 8'(tCAS + tBURST - 3);
  localparam logic [7:0] LD_WR  = 8'(tCWL + tBURST + tWR - 3);
  localparam logic [7:0] LD_RP  = 8'(tRP - 2);
  state_t      state, nxt;
  logic [7:0]  cnt;
  logic        rdy_q, wr_q, ch_q;
  logic [2:0]  bg_q;
  logic [1:0]  bank_q;
  logic [15:0] row_q;
  logic [9:0]  col_q;
  logic        accept;
  logic        addr_unused;
  assign accept      = req_valid & req_ready;
  assign addr_unused = ^{req_addr[35:34], req_addr[1:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rdy_q, wr_q, ch_q, bg_q, bank_q, row_q, col_q} <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      req_err <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      done    <= state == WAIT_RP && cnt == 8'd0;
      req_err <= accept && req_op == 2'd3;
      cnt     <= state != nxt ? (nxt == WAIT_RCD ? LD_RCD : nxt == WAIT_PRE ? (wr_q ? LD_WR : LD_RD) : LD_RP)
                              : cnt - 8'd1;
      if (accept) begin
        wr_q   <= req_op == 2'd1;
        ch_q   <= req_addr[6];
        bg_q   <= req_addr[9:7];
        bank_q <= req_addr[11:10];
        row_q  <= req_addr[33:18];
        col_q  <= {req_addr[17:12], req_addr[5:2]};
      end
    end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     nxt = accept && req_op != 2'd3 ? ACT0 : IDLE;
      ACT0:     nxt = ACT1;
      ACT1:     nxt = tRCD == 2 ? CAS0 : WAIT_RCD;
      WAIT_RCD: nxt = cnt == 8'd0 ? CAS0 : WAIT_RCD;
      CAS0:     nxt = CAS1;
      CAS1:     nxt = WAIT_PRE;
      WAIT_PRE: nxt = cnt == 8'd0 ? PRE : WAIT_PRE;
      PRE:      nxt = WAIT_RP;
      WAIT_RP:  nxt = cnt == 8'd0 ? IDLE : WAIT_RP;
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    busy        = state != IDLE;
    req_ready   = state == IDLE && rdy_q;
    cmd_valid   = state inside {ACT0, ACT1, CAS0, CAS1, PRE};
    cmd_type    = state == ACT1 ? 3'd1 :
                  state == CAS0 ? (wr_q ? 3'd4 : 3'd2) :
                  state == CAS1 ? (wr_q ? 3'd5 : 3'd3) :
                  state == PRE  ? 3'd6 : 3'd0;
    cmd_channel = busy ? ch_q : 1'b0;
    cmd_bg      = busy ? bg_q : 3'd0;
    cmd_bank    = busy ? bank_q : 2'd0;
    cmd_row     = busy ? row_q : 16'd0;
    cmd_col     = busy ? col_q : 10'd0;
  end
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// tb_dram_cmd_sequencer: checks a default and an all-minimum build against a schedule model.
module tb_dram_cmd_sequencer;
  localparam logic [35:0] ADDR = 36'h0_48D2_AAF0;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [35:0] req_addr = 36'd0;
  logic rdy[2], cv[2], bs[2], dn[2], er[2], ch[2];
  logic [2:0] ty[2], bgv[2];
  logic [1:0] bk[2];
  logic [15:0] rw[2];
  logic [9:0] cl[2];
  int tests = 0, fails = 0, cyc = 0;
  logic rdy_m = 1'b0;
  int ma[2] = '{-1, -1}, mc[2] = '{-1, -1}, mp[2] = '{-1, -1}, md[2] = '{-1, -1}, me[2] = '{-1, -1};
  logic mwr[2], mch[2];
  logic [2:0] mbg[2];
  logic [1:0] mbk[2];
  logic [15:0] mrow[2];
  logic [9:0] mcol[2];
  int seen[2][8];
  int seen_done[2], seen_err[2];
  int pulses[2] = '{0, 0};
  logic cap_ch;
  logic [2:0] cap_bg;
  logic [1:0] cap_bk;
  logic [15:0] cap_row;
  logic [9:0] cap_col;
  logic eb, ev, ed, ee, erd, cas;
  logic [2:0] et;
  logic [39:0] gv, xv;

  dram_cmd_sequencer dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_op(req_op), .req_addr(req_addr),
    .cmd_valid(cv[0]), .cmd_type(ty[0]), .cmd_channel(ch[0]), .cmd_bg(bgv[0]), .cmd_bank(bk[0]),
    .cmd_row(rw[0]), .cmd_col(cl[0]), .busy(bs[0]), .done(dn[0]), .req_err(er[0]));
  dram_cmd_sequencer #(.tRCD(2), .tCAS(2), .tCWL(2), .tBURST(2), .tWR(2), .tRP(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_op(req_op), .req_addr(req_addr),
    .cmd_valid(cv[1]), .cmd_type(ty[1]), .cmd_channel(ch[1]), .cmd_bg(bgv[1]), .cmd_bank(bk[1]),
    .cmd_row(rw[1]), .cmd_col(cl[1]), .busy(bs[1]), .done(dn[1]), .req_err(er[1]));

  function automatic int rcd(int k);
    return k == 0 ? 39 : 2;
  endfunction
  function automatic int cas_to_pre(int k, logic w);
    if (k == 0) return w ? 38 + 8 + 72 : 40 + 8;
    return w ? 2 + 2 + 2 : 2 + 2;
  endfunction
  function automatic int rp(int k);
    return k == 0 ? 39 : 2;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdy_m <= !rst;
  end

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      eb  = !rst && ma[k] >= 0 && cyc >= ma[k] && cyc < md[k];
      erd = !rst && rdy_m && !eb;
      ev  = !rst && ma[k] >= 0 && (cyc == ma[k] || cyc == ma[k] + 1 || cyc == mc[k] || cyc == mc[k] + 1 || cyc == mp[k]);
      et  = cyc == ma[k] ? 3'd0 : cyc == ma[k] + 1 ? 3'd1 : cyc == mc[k] ? (mwr[k] ? 3'd4 : 3'd2) :
            cyc == mc[k] + 1 ? (mwr[k] ? 3'd5 : 3'd3) : 3'd6;
      ed  = !rst && cyc == md[k];
      ee  = !rst && cyc == me[k];
      cas = ev && et >= 3'd2 && et <= 3'd5;
      gv  = {rdy[k], cv[k], bs[k], dn[k], er[k], cv[k] ? ty[k] : 3'd0, ch[k], bgv[k], bk[k], rw[k], cas ? cl[k] : 10'd0};
      xv  = {erd, ev, eb, ed, ee, ev ? et : 3'd0, eb ? {mch[k], mbg[k], mbk[k], mrow[k]} : 22'd0, cas ? mcol[k] : 10'd0};
      tests++;
      if (gv !== xv) begin
        fails++;
        $display("FAIL cycle_check dut%0d cyc %0d: got %h expected %h", k, cyc, gv, xv);
      end
      if (cv[k]) begin
        seen[k][ty[k]] = cyc;
        pulses[k]++;
        if (k == 0 && (ty[k] == 3'd2 || ty[k] == 3'd4)) {cap_ch, cap_bg, cap_bk, cap_row, cap_col} = {ch[k], bgv[k], bk[k], rw[k], cl[k]};
      end
      if (dn[k]) seen_done[k] = cyc;
      if (er[k]) seen_err[k] = cyc;
      if (rst) begin
        ma[k] = -1; mc[k] = -1; mp[k] = -1; md[k] = -1; me[k] = -1;
      end else if (req_valid && erd) begin
        if (req_op == 2'd3) me[k] = cyc + 1;
        else begin
          mwr[k]  = req_op == 2'd1;
          ma[k]   = cyc + 1;
          mc[k]   = ma[k] + rcd(k);
          mp[k]   = mc[k] + cas_to_pre(k, mwr[k]);
          md[k]   = mp[k] + rp(k);
          mch[k]  = req_addr[6];
          mbg[k]  = req_addr[9:7];
          mbk[k]  = req_addr[11:10];
          mrow[k] = req_addr[33:18];
          mcol[k] = {req_addr[17:12], req_addr[5:2]};
        end
      end
    end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_acc(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rdy[0] && req_valid) begin
        t = cyc;
        break;
      end
    end
    tests++;
    if (t < 0) begin
      fails++;
      $display("FAIL accept_timeout: got none expected accept within 400 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dn[0]) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout: got none expected done within 400 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [35:0] a, output int t);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    wait_acc(t);
    req_valid = 1'b0;
  endtask

  initial begin
    int t, t2, p0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", rdy[0], 0);
    chk("reset_cmd_valid", cv[0], 0);
    chk("reset_busy", bs[0], 0);
    rst = 1'b0;
    @(negedge clk) chk("ready_low_at_release", rdy[0], 0);
    @(negedge clk) chk("ready_after_release", rdy[0], 1);

    send(2'd0, ADDR, t);
    wait_done();
    chk("rd_act0", seen[0][0] - t, 1);
    chk("rd_act1", seen[0][1] - t, 2);
    chk("rd_rd0", seen[0][2] - t, 40);
    chk("rd_rd1", seen[0][3] - t, 41);
    chk("rd_pre", seen[0][6] - t, 88);
    chk("rd_done", seen_done[0] - t, 127);
    chk("rd_ch", cap_ch, 1);
    chk("rd_bg", cap_bg, 5);
    chk("rd_bank", cap_bk, 2);
    chk("rd_row", cap_row, 16'h1234);
    chk("rd_col", cap_col, 10'h2AC);
    chk("min_act0", seen[1][0] - t, 1);
    chk("min_act1", seen[1][1] - t, 2);
    chk("min_rd0", seen[1][2] - t, 3);
    chk("min_rd1", seen[1][3] - t, 4);
    chk("min_pre", seen[1][6] - t, 7);
    chk("min_done", seen_done[1] - t, 9);

    send(2'd1, ADDR, t);
    wait_done();
    chk("wr_wr0", seen[0][4] - t, 40);
    chk("wr_wr1", seen[0][5] - t, 41);
    chk("wr_pre", seen[0][6] - t, 158);
    chk("wr_done", seen_done[0] - t, 197);

    send(2'd2, ADDR, t);
    wait_done();
    chk("if_rd0", seen[0][2] - t, 40);
    chk("if_rd1", seen[0][3] - t, 41);
    chk("if_pre", seen[0][6] - t, 88);
    chk("if_done", seen_done[0] - t, 127);

    p0 = pulses[0];
    send(2'd3, ADDR, t);
    repeat (5) @(posedge clk);
    #1;
    chk("illegal_err", seen_err[0] - t, 1);
    chk("illegal_no_cmd", pulses[0] - p0, 0);
    chk("illegal_ready", rdy[0], 1);

    p0 = pulses[0];
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_addr  = ADDR;
    wait_acc(t);
    wait_acc(t2);
    req_valid = 1'b0;
    wait_done();
    chk("b2b_accept", t2 - t, 127);
    chk("b2b_act0", seen[0][0] - t2, 1);
    chk("b2b_pulses", pulses[0] - p0, 10);

    send(2'd0, ADDR, t);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_cmd_valid", cv[0], 0);
    chk("rst_busy", bs[0], 0);
    chk("rst_ready", rdy[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = pulses[0];
    @(negedge clk) chk("rst_ready_low", rdy[0], 0);
    @(negedge clk) chk("rst_ready_high", rdy[0], 1);
    repeat (100) @(posedge clk);
    #1;
    chk("rst_no_pre", pulses[0] - p0, 0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom % 600) == 0;
      req_valid = ($urandom % 4) == 0;
      req_op    = 2'($urandom);
      req_addr  = {4'($urandom), $urandom};
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
